// File: rtl/decode_stage.sv
// MIPS-subset decode stage: decodes one instruction per cycle into a small FIFO.
// Includes a shared INST_* code package, a RUN/HALTED state machine and a saturating illegal-instruction counter.

package decode_pkg;
    localparam logic [5:0] INST_NOP   = 6'd0;
    localparam logic [5:0] INST_ADDU  = 6'd1;
    localparam logic [5:0] INST_SUBU  = 6'd2;
    localparam logic [5:0] INST_SLT   = 6'd3;
    localparam logic [5:0] INST_SRAV  = 6'd4;
    localparam logic [5:0] INST_JR    = 6'd5;
    localparam logic [5:0] INST_ORI   = 6'd6;
    localparam logic [5:0] INST_LW    = 6'd7;
    localparam logic [5:0] INST_SW    = 6'd8;
    localparam logic [5:0] INST_BEQ   = 6'd9;
    localparam logic [5:0] INST_LUI   = 6'd10;
    localparam logic [5:0] INST_J     = 6'd11;
    localparam logic [5:0] INST_ADDI  = 6'd12;
    localparam logic [5:0] INST_ADDIU = 6'd13;
    localparam logic [5:0] INST_JAL   = 6'd14;
    localparam logic [5:0] INST_HLT   = 6'd15;
    localparam logic [5:0] INST_LB    = 6'd16;
    localparam logic [5:0] INST_SB    = 6'd17;
endpackage

module decode_stage
    import decode_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int BYTE_OPS = 1,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_inst,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [DATA_W-1:0] out_imm,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  ill_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              full;
    logic              push;
    logic              pop;

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic [5:0]        dec_inst;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_illegal;

    logic [5:0]        inst_q  [DEPTH];
    logic [4:0]        rs_q    [DEPTH];
    logic [4:0]        rt_q    [DEPTH];
    logic [4:0]        rd_q    [DEPTH];
    logic [4:0]        shamt_q [DEPTH];
    logic [DATA_W-1:0] imm_q   [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];

    assign opcode = in_inst[31:26];
    assign rs     = in_inst[25:21];
    assign rt     = in_inst[20:16];
    assign rd     = in_inst[15:11];
    assign shamt  = in_inst[10:6];
    assign funct  = in_inst[5:0];
    assign imm16  = in_inst[15:0];

    always_comb begin
        dec_inst = INST_NOP;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: dec_inst = INST_ADDU;
                    6'b100011: dec_inst = INST_SUBU;
                    6'b101010: dec_inst = INST_SLT;
                    6'b000111: if (shamt == 5'd0) dec_inst = INST_SRAV;
                    6'b001000: if (rt == 5'd0 && rd == 5'd0) dec_inst = INST_JR;
                    default:   dec_inst = INST_NOP;
                endcase
            end
            6'b001101: dec_inst = INST_ORI;
            6'b100011: dec_inst = INST_LW;
            6'b101011: dec_inst = INST_SW;
            6'b000100: dec_inst = INST_BEQ;
            6'b001111: if (rs == 5'd0) dec_inst = INST_LUI;
            6'b000010: dec_inst = INST_J;
            6'b001000: dec_inst = INST_ADDI;
            6'b001001: dec_inst = INST_ADDIU;
            6'b000011: dec_inst = INST_JAL;
            6'b111111: dec_inst = INST_HLT;
            6'b100000: if (BYTE_OPS != 0) dec_inst = INST_LB;
            6'b101000: if (BYTE_OPS != 0) dec_inst = INST_SB;
            default:   dec_inst = INST_NOP;
        endcase
    end

    // ORI and LUI carry a logical immediate; everything else is signed
    assign dec_imm = (dec_inst == INST_ORI || dec_inst == INST_LUI)
                   ? {{(DATA_W-16){1'b0}}, imm16}
                   : {{(DATA_W-16){imm16[15]}}, imm16};

    assign dec_illegal = (dec_inst == INST_NOP) && (in_inst != 32'd0);

    assign full      = (count == FULL_CNT);
    assign in_ready  = !full && (state == RUN) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr]  <= dec_inst;
            rs_q[wr_ptr]    <= rs;
            rt_q[wr_ptr]    <= rt;
            rd_q[wr_ptr]    <= rd;
            shamt_q[wr_ptr] <= shamt;
            imm_q[wr_ptr]   <= dec_imm;
            pc_q[wr_ptr]    <= in_pc;
        end
    end

    assign out_inst  = inst_q[rd_ptr];
    assign out_rs    = rs_q[rd_ptr];
    assign out_rt    = rt_q[rd_ptr];
    assign out_rd    = rd_q[rd_ptr];
    assign out_shamt = shamt_q[rd_ptr];
    assign out_imm   = imm_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (push && dec_inst == INST_HLT) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (push && dec_illegal && ill_cnt != '1) begin
            ill_cnt <= ill_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default instance plus a BYTE_OPS=0, CNT_W=2 instance.

module tb_decode_stage;
    import decode_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_inst;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        flush;
    logic        halted;
    logic [7:0]  ill_cnt;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_inst;
    logic [31:0] b_in_pc;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [5:0]  b_out_inst;
    logic [4:0]  b_out_rs;
    logic [4:0]  b_out_rt;
    logic [4:0]  b_out_rd;
    logic [4:0]  b_out_shamt;
    logic [31:0] b_out_imm;
    logic [31:0] b_out_pc;
    logic        b_flush;
    logic        b_halted;
    logic [1:0]  b_ill_cnt;

    int tests;
    int fails;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_pc(out_pc),
        .flush(flush), .halted(halted), .ill_cnt(ill_cnt)
    );

    decode_stage #(.BYTE_OPS(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst),
        .out_rs(b_out_rs), .out_rt(b_out_rt), .out_rd(b_out_rd), .out_shamt(b_out_shamt),
        .out_imm(b_out_imm), .out_pc(b_out_pc),
        .flush(b_flush), .halted(b_halted), .ill_cnt(b_ill_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = valid;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1; flush = 1'b0;
        b_in_valid = 1'b0; b_in_inst = '0; b_in_pc = '0; b_out_ready = 1'b1; b_flush = 1'b0;

        #12;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_ill_cnt", ill_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_in_ready", in_ready, 1);

        // basic ADDU with one-cycle latency
        applyStimulus(1, 32'h012A4021, 32'h100);
        tick();
        applyStimulus(0, 0, 0);
        checkOutput("addu_valid", out_valid, 1);
        checkOutput("addu_inst", out_inst, INST_ADDU);
        checkOutput("addu_rs", out_rs, 9);
        checkOutput("addu_rt", out_rt, 10);
        checkOutput("addu_rd", out_rd, 8);
        checkOutput("addu_pc", out_pc, 32'h100);
        tick();
        checkOutput("addu_drained", out_valid, 0);

        // immediate extension and LUI with rs!=0
        applyStimulus(1, 32'h3C01FFFF, 32'h104);
        tick();
        checkOutput("lui_inst", out_inst, INST_LUI);
        checkOutput("lui_imm", out_imm, 32'h0000FFFF);
        applyStimulus(1, 32'h2021FFFF, 32'h108);
        tick();
        checkOutput("addi_inst", out_inst, INST_ADDI);
        checkOutput("addi_imm", out_imm, 32'hFFFFFFFF);
        checkOutput("addi_pc", out_pc, 32'h108);
        applyStimulus(1, 32'h3C21FFFF, 32'h10C);
        tick();
        checkOutput("badlui_inst", out_inst, INST_NOP);
        checkOutput("badlui_ill", ill_cnt, 1);

        // JR, all-zero word (not illegal), LB, SRAV with shamt
        applyStimulus(1, 32'h01000008, 32'h110);
        tick();
        checkOutput("jr_inst", out_inst, INST_JR);
        applyStimulus(1, 32'h00000000, 32'h114);
        tick();
        checkOutput("zero_inst", out_inst, INST_NOP);
        checkOutput("zero_ill", ill_cnt, 1);
        applyStimulus(1, 32'h80220004, 32'h118);
        tick();
        checkOutput("lb_inst", out_inst, INST_LB);
        checkOutput("lb_imm", out_imm, 32'h4);
        applyStimulus(1, 32'h01095047, 32'h11C);
        tick();
        checkOutput("srav_sh_inst", out_inst, INST_NOP);
        checkOutput("srav_sh_ill", ill_cnt, 2);
        applyStimulus(0, 0, 0);
        tick();
        checkOutput("empty_again", out_valid, 0);

        // backpressure with DEPTH=2
        out_ready = 1'b0;
        applyStimulus(1, 32'h01095023, 32'h200);
        tick();
        checkOutput("bp1_ready", in_ready, 1);
        applyStimulus(1, 32'h0109582A, 32'h204);
        tick();
        checkOutput("bp2_ready", in_ready, 0);
        checkOutput("bp2_head", out_inst, INST_SUBU);
        applyStimulus(1, 32'h35088001, 32'h208);
        tick();
        checkOutput("bp3_ready", in_ready, 0);
        checkOutput("bp3_head_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp4_ready", in_ready, 1);
        checkOutput("bp4_head", out_inst, INST_SLT);
        checkOutput("bp4_head_pc", out_pc, 32'h204);
        tick();
        applyStimulus(0, 0, 0);
        out_ready = 1'b1;
        checkOutput("bp5_ready", in_ready, 0);
        checkOutput("bp5_head", out_inst, INST_SLT);
        tick();
        checkOutput("bp6_head", out_inst, INST_ORI);
        checkOutput("bp6_imm", out_imm, 32'h00008001);
        checkOutput("bp6_pc", out_pc, 32'h208);
        tick();
        checkOutput("bp7_empty", out_valid, 0);

        // flush beats a simultaneous offer
        out_ready = 1'b0;
        applyStimulus(1, 32'h012A4021, 32'h300);
        tick();
        applyStimulus(1, 32'h8D090004, 32'h304);
        tick();
        checkOutput("fl_full", in_ready, 0);
        out_ready = 1'b1;
        flush = 1'b1;
        applyStimulus(1, 32'h3C21FFFF, 32'h308);
        #1;
        checkOutput("fl_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        applyStimulus(0, 0, 0);
        checkOutput("fl_valid", out_valid, 0);
        checkOutput("fl_ill", ill_cnt, 2);
        applyStimulus(1, 32'h8D090004, 32'h30C);
        tick();
        applyStimulus(0, 0, 0);
        checkOutput("postfl_inst", out_inst, INST_LW);
        checkOutput("postfl_pc", out_pc, 32'h30C);
        tick();

        // HLT then ADDU offered; only a reset restarts intake
        out_ready = 1'b0;
        applyStimulus(1, 32'hFC000000, 32'h400);
        tick();
        applyStimulus(1, 32'h012A4021, 32'h404);
        checkOutput("hlt_halted", halted, 1);
        checkOutput("hlt_ready", in_ready, 0);
        checkOutput("hlt_head", out_inst, INST_HLT);
        out_ready = 1'b1;
        tick();
        checkOutput("hlt_drained", out_valid, 0);
        tick();
        tick();
        checkOutput("hlt_no_addu", out_valid, 0);
        checkOutput("hlt_still", halted, 1);
        rst_n = 1'b0;
        #2;
        checkOutput("rst2_halted", halted, 0);
        checkOutput("rst2_ill", ill_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 0, 0);
        checkOutput("rst2_addu_valid", out_valid, 1);
        checkOutput("rst2_addu_inst", out_inst, INST_ADDU);
        tick();

        // second instance: LB as NOP, 2-bit counter saturation
        b_in_valid = 1'b1;
        b_in_inst  = 32'h80220004;
        b_in_pc    = 32'h500;
        tick();
        checkOutput("b_lb_inst", b_out_inst, INST_NOP);
        checkOutput("b_lb_ill", b_ill_cnt, 1);
        b_in_inst = 32'h3C21FFFF;
        for (int i = 0; i < 4; i++) tick();
        b_in_valid = 1'b0;
        checkOutput("b_ill_sat", b_ill_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
